// File: rtl/cnn_conv_acc_relu_if.sv
// Stream bundle between the conv multiplier, the accumulation stage and the
// output buffer. The product side and the result side each carry a
// valid/ready handshake.
// The slave modport is the accumulation stage.
// The master modport is the environment driving products and taking results.
interface cnn_conv_acc_relu_if #(
    parameter int PROD_WIDTH = 20,
    parameter int BIAS_WIDTH = 14,
    parameter int OUT_WIDTH  = 14
);
    logic signed [PROD_WIDTH-1:0] prod_data;
    logic                         prod_valid;
    logic                         prod_ready;
    logic signed [BIAS_WIDTH-1:0] bias_data;
    logic signed [OUT_WIDTH-1:0]  out_data;
    logic                         out_sat;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output prod_data, prod_valid, bias_data, out_ready,
        input  prod_ready, out_data, out_sat, out_valid
    );

    modport slave (
        input  prod_data, prod_valid, bias_data, out_ready,
        output prod_ready, out_data, out_sat, out_valid
    );
endinterface

// File: rtl/cnn_conv_acc_relu.sv
// Post-multiplier accumulation stage of the convolution datapath.
// The stage sums TAPS signed products per window, seeded with bias << SHIFT.
// It requantizes the sum with round-half-up and a right shift by SHIFT.
// It then saturates the result to OUT_WIDTH and offers it on a one-entry
// output register.
// Optional feature macro: CNN_ACC_RELU_EN. When it is defined, negative
// results are forced to zero before clamping (ReLU).
// Only the finalizing tap can stall on a full output register. Every other
// tap of the next window overlaps a stalled result.
module cnn_conv_acc_relu #(
    parameter int PROD_WIDTH = 20,
    parameter int TAPS       = 9,
    parameter int ACC_WIDTH  = 26,
    parameter int BIAS_WIDTH = 14,
    parameter int SHIFT      = 5,
    parameter int OUT_WIDTH  = 14
) (
    input logic                ap_clk,
    input logic                ap_rst_n,
    cnn_conv_acc_relu_if.slave bus
);
    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_TAP_C = CNT_W'(TAPS - 1);
    // One extra bit keeps the rounding addend from overflowing the sum.
    localparam int RQ_W = ACC_WIDTH + 1;
    localparam logic signed [RQ_W-1:0] RND_C     = RQ_W'(32'sd1 <<< (SHIFT - 1));
    localparam logic signed [RQ_W-1:0] OUT_MAX_C = RQ_W'((32'sd1 <<< (OUT_WIDTH - 1)) - 32'sd1);
    localparam logic signed [RQ_W-1:0] OUT_MIN_C = ~OUT_MAX_C;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Round half up, shift, optional ReLU, then clamp. Returns {sat, data}.
    function automatic logic [OUT_WIDTH:0] requant(input logic signed [ACC_WIDTH-1:0] sum);
        logic signed [RQ_W-1:0] rnd;
        logic signed [RQ_W-1:0] r;
        logic [OUT_WIDTH-1:0]   data;
        logic                   sat;
        rnd = RQ_W'(sum) + RND_C;
        r   = rnd >>> SHIFT;
`ifdef CNN_ACC_RELU_EN
        // ReLU zeroing happens before the clamp and is never reported as saturation.
        r   = r[RQ_W-1] ? {RQ_W{1'b0}} : r;
`endif
        if (r > OUT_MAX_C) begin
            data = OUT_MAX_C[OUT_WIDTH-1:0];
            sat  = 1'b1;
        end else if (r < OUT_MIN_C) begin
            data = OUT_MIN_C[OUT_WIDTH-1:0];
            sat  = 1'b1;
        end else begin
            data = r[OUT_WIDTH-1:0];
            sat  = 1'b0;
        end
        return {sat, data};
    endfunction

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    out_state_e                  state_q, state_d;
    logic [OUT_WIDTH-1:0]        out_data_q, out_data_d;
    logic                        out_sat_q, out_sat_d;

    logic                        last_tap_s;
    logic                        prod_ready_s;
    logic                        prod_xfer_s;
    logic                        out_xfer_s;
    logic                        finalize_s;
    logic signed [ACC_WIDTH-1:0] prod_ext_s;
    logic signed [ACC_WIDTH-1:0] bias_ext_s;
    logic signed [ACC_WIDTH-1:0] sum_s;
    logic [OUT_WIDTH:0]          rq_s;

    // Handshake qualifiers. prod_ready depends on out_ready, never on prod_valid.
    always_comb begin
        last_tap_s   = (cnt_q == LAST_TAP_C);
        prod_ready_s = !(last_tap_s && (state_q == OUT_FULL) && !bus.out_ready);
        prod_xfer_s  = bus.prod_valid && prod_ready_s;
        out_xfer_s   = (state_q == OUT_FULL) && bus.out_ready;
        finalize_s   = prod_xfer_s && last_tap_s;
    end

    // Tap counter, accumulator and requantized window sum.
    always_comb begin
        prod_ext_s = ACC_WIDTH'(bus.prod_data);
        bias_ext_s = ACC_WIDTH'(bus.bias_data) <<< SHIFT;
        sum_s      = acc_q + prod_ext_s;
        rq_s       = requant(sum_s);
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        if (prod_xfer_s) begin
            if (last_tap_s) begin
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_q == {CNT_W{1'b0}}) begin
                acc_d = bias_ext_s + prod_ext_s;
            end else begin
                acc_d = sum_s;
            end
        end else begin
            cnt_d = cnt_q;
            acc_d = acc_q;
        end
    end

    // Output register occupancy; it reloads on finalize even while draining.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            OUT_EMPTY: begin
                if (finalize_s) begin
                    state_d = OUT_FULL;
                end else begin
                    state_d = OUT_EMPTY;
                end
            end
            OUT_FULL: begin
                if (finalize_s) begin
                    state_d = OUT_FULL;
                end else if (out_xfer_s) begin
                    state_d = OUT_EMPTY;
                end else begin
                    state_d = OUT_FULL;
                end
            end
            default: begin
                state_d = OUT_EMPTY;
            end
        endcase
        if (finalize_s) begin
            out_data_d = rq_s[OUT_WIDTH-1:0];
            out_sat_d  = rq_s[OUT_WIDTH];
        end else begin
            out_data_d = out_data_q;
            out_sat_d  = out_sat_q;
        end
    end

    // State registers; reset drops any partial window and pending result.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt_q      <= {CNT_W{1'b0}};
            acc_q      <= {ACC_WIDTH{1'b0}};
            state_q    <= OUT_EMPTY;
            out_data_q <= {OUT_WIDTH{1'b0}};
            out_sat_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    assign bus.prod_ready = prod_ready_s;
    assign bus.out_valid  = (state_q == OUT_FULL);
    assign bus.out_data   = out_data_q;
    assign bus.out_sat    = out_sat_q;
endmodule

// File: tb/tb_cnn_conv_acc_relu.sv
// Directed bench for cnn_conv_acc_relu with hand-computed expected results.
// Expectations follow CNN_ACC_RELU_EN when the bench is built with it.
module tb_cnn_conv_acc_relu;
    localparam int PROD_WIDTH = 20;
    localparam int TAPS       = 9;
    localparam int ACC_WIDTH  = 26;
    localparam int BIAS_WIDTH = 14;
    localparam int SHIFT      = 5;
    localparam int OUT_WIDTH  = 14;

`ifdef CNN_ACC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   res_q[$];

    cnn_conv_acc_relu_if #(
        .PROD_WIDTH(PROD_WIDTH),
        .BIAS_WIDTH(BIAS_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) bus ();

    cnn_conv_acc_relu #(
        .PROD_WIDTH(PROD_WIDTH),
        .TAPS      (TAPS),
        .ACC_WIDTH (ACC_WIDTH),
        .BIAS_WIDTH(BIAS_WIDTH),
        .SHIFT     (SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
    ) dut (
        .ap_clk  (clk),
        .ap_rst_n(rst_n),
        .bus     (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Collect every result transfer, sampled on the falling edge before it happens.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            res_q.push_back(int'(bus.out_data));
        end
    end

    task automatic check_value(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present one product and wait (bounded) for it to be accepted.
    task automatic send_prod(input int p, input int b);
        int waited;
        waited         = 0;
        bus.prod_data  = PROD_WIDTH'(p);
        bus.bias_data  = BIAS_WIDTH'(b);
        bus.prod_valid = 1'b1;
        @(negedge clk);
        while (!bus.prod_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        check_value("prod_accept", int'(bus.prod_ready), 1);
        @(posedge clk);
        #1;
        bus.prod_valid = 1'b0;
    endtask

    // One window: first tap p0 with bias b, remaining taps prest.
    task automatic send_window(input int b, input int p0, input int prest);
        for (int i = 0; i < TAPS; i++) begin
            send_prod((i == 0) ? p0 : prest, b);
        end
    endtask

    task automatic expect_out(input string tag, input int d, input int s);
        check_value({tag, "_valid"}, int'(bus.out_valid), 1);
        check_value({tag, "_data"}, int'(bus.out_data), d);
        check_value({tag, "_sat"}, int'(bus.out_sat), s);
    endtask

    // Hard stop in case the stimulus itself gets stuck.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        bus.prod_data  = '0;
        bus.prod_valid = 1'b0;
        bus.bias_data  = '0;
        bus.out_ready  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_out_valid", int'(bus.out_valid), 0);
        check_value("rst_out_data", int'(bus.out_data), 0);
        check_value("rst_out_sat", int'(bus.out_sat), 0);
        check_value("rst_prod_ready", int'(bus.prod_ready), 1);
        rst_n = 1'b1;

        // Nine products of 32: (288+16)>>>5 = 9, single-cycle valid pulse
        for (int i = 0; i < TAPS - 1; i++) send_prod(32, 0);
        check_value("t1_no_early_valid", int'(bus.out_valid), 0);
        send_prod(32, 0);
        expect_out("t1", 9, 0);
        @(posedge clk);
        #1;
        check_value("t1_valid_pulse", int'(bus.out_valid), 0);

        // Nine products of -100: (-900+16)>>>5 = -28
        send_window(0, -100, -100);
        expect_out("t2", RELU ? 0 : -28, 0);

        // Positive overflow: 9*524287 -> clamp 8191
        send_window(0, 524287, 524287);
        expect_out("t3", 8191, 1);

        // Negative overflow: 9*(-524288) -> clamp -8192 (0 with ReLU)
        send_window(0, -524288, -524288);
        expect_out("t4", RELU ? 0 : -8192, RELU ? 0 : 1);

        // Bias 3, zero products; bias on later taps must be ignored
        send_prod(0, 3);
        for (int i = 1; i < TAPS; i++) send_prod(0, 100);
        expect_out("t5", 3, 0);

        // Largest bias lands exactly on the positive rail without clamping
        send_window(8191, 0, 0);
        expect_out("t6", 8191, 0);

        // One LSB over the rail: (262144+16)>>>5 = 8192 -> clamp
        send_window(8191, 32, 0);
        expect_out("t7", 8191, 1);

        // Rounding half up: 16 -> 1, 15 -> 0, -17 -> -1
        send_window(0, 16, 0);
        expect_out("t8", 1, 0);
        send_window(0, 15, 0);
        expect_out("t9", 0, 0);
        send_window(0, -17, 0);
        expect_out("t10", RELU ? 0 : -1, 0);

        // Backpressure: window 1 parked, window 2 streams until its last tap
        @(posedge clk);
        #1;
        res_q.delete();
        bus.out_ready = 1'b0;
        send_window(0, 32, 32);
        expect_out("bp_w1", 9, 0);
        for (int i = 0; i < TAPS - 1; i++) begin
            check_value("bp_ready_tap", int'(bus.prod_ready), 1);
            send_prod(64, 0);
        end
        bus.prod_data  = PROD_WIDTH'(64);
        bus.prod_valid = 1'b1;
        @(negedge clk);
        check_value("bp_stall_ready", int'(bus.prod_ready), 0);
        check_value("bp_hold_data", int'(bus.out_data), 9);
        @(negedge clk);
        check_value("bp_stall_ready2", int'(bus.prod_ready), 0);
        check_value("bp_hold_valid", int'(bus.out_valid), 1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        #1;
        check_value("bp_release_ready", int'(bus.prod_ready), 1);
        @(posedge clk);
        #1;
        bus.prod_valid = 1'b0;
        expect_out("bp_w2", 18, 0);
        @(posedge clk);
        #1;
        check_value("bp_drained", int'(bus.out_valid), 0);
        check_value("bp_count", res_q.size(), 2);
        if (res_q.size() == 2) begin
            check_value("bp_order0", res_q[0], 9);
            check_value("bp_order1", res_q[1], 18);
        end

        // Reset mid-window with a pending result
        bus.out_ready = 1'b0;
        send_window(0, 32, 32);
        for (int i = 0; i < 4; i++) send_prod(100, 0);
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_valid", int'(bus.out_valid), 0);
        check_value("mid_rst_data", int'(bus.out_data), 0);
        check_value("mid_rst_ready", int'(bus.prod_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send_window(0, 64, 64);
        expect_out("post_rst", 18, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
